// File: rtl/sdram_pkg.sv
// Shared constants, state type and halfword select helper for the channel-1 line buffer.
package sdram_pkg;
  localparam int HW_W      = 16;
  localparam int LINE_W    = 64;
  // Channel-1 bursts are 8-byte aligned: 3 byte-address LSBs, 2 halfword-address LSBs.
  localparam int CH1_ALIGN = 3;
  localparam int OFF_W     = CH1_ALIGN - 1;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_FILL, WR_WAIT} linebuf_state_t;

  // Pick halfword off (narrow) or {off+1, off} (wide) from a line; never crosses lines.
  function automatic logic [31:0] hw_sel(input logic [LINE_W-1:0] line,
                                         input logic [OFF_W-1:0]  off,
                                         input logic              wide);
    logic [OFF_W-1:0] off1;
    off1   = off + 2'd1;
    hw_sel = {wide ? line[{off1, 4'b0} +: HW_W] : 16'h0, line[{off, 4'b0} +: HW_W]};
  endfunction
endpackage

// File: rtl/sdram_linebuf_store.sv
// Direct-mapped tag/valid/data arrays: combinational lookup, fill, halfword merge, flush.
module sdram_linebuf_store
  import sdram_pkg::*;
#(
  parameter int LINES = 4,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 26 - OFF_W - IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  lk_idx,
  input  logic [TAG_W-1:0]  lk_tag,
  output logic              lk_hit,
  output logic [LINE_W-1:0] lk_line,
  input  logic              fill_en,
  input  logic [IDX_W-1:0]  fill_idx,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_line,
  input  logic              fill_valid,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [HW_W-1:0]   wr_data,
  input  logic              flush
);
  logic [LINES-1:0][LINE_W-1:0] data;
  logic [LINES-1:0][TAG_W-1:0]  tag;
  logic [LINES-1:0]             valid;

  assign lk_hit  = valid[lk_idx] && (tag[lk_idx] == lk_tag);
  assign lk_line = data[lk_idx];

  // Fill, then merge, then flush: a flush in the same cycle always leaves every line invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      tag   <= '0;
      valid <= '0;
    end else begin
      if (fill_en) begin
        data[fill_idx]  <= fill_line;
        tag[fill_idx]   <= fill_tag;
        valid[fill_idx] <= fill_valid;
      end
      if (wr_en && valid[wr_idx] && (tag[wr_idx] == wr_tag))
        data[wr_idx][{wr_off, 4'b0} +: HW_W] <= wr_data;
      if (flush)
        valid <= '0;
    end
  end
endmodule

// File: rtl/sdram_rom_linebuf.sv
// ROM read cache in front of SDRAM channel 1: one burst per miss, writes pass through
// and are merged into a resident line so later hits see the patched data.
module sdram_rom_linebuf
  import sdram_pkg::*;
#(
  parameter int LINES = 4,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic [25:0] cpu_addr,
  input  logic        cpu_req,
  input  logic        cpu_rnw,
  input  logic        cpu_wide,
  input  logic [15:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        cpu_ack,
  output logic        cpu_busy,
  input  logic        flush,
  output logic [25:0] ch1_addr,
  output logic [15:0] ch1_din,
  output logic        ch1_req,
  output logic        ch1_rnw,
  input  logic [63:0] ch1_dout,
  input  logic        ch1_ready
);
  localparam int TAG_W = 26 - OFF_W - IDX_W;

  linebuf_state_t    state;
  logic [25:0]       req_addr;
  logic              req_wide;
  logic [31:0]       dout_q;
  logic              fill_flushed;
  logic              lk_hit;
  logic [LINE_W-1:0] lk_line;
  logic              accept;

  assign accept = cpu_req && !cpu_busy && (state == IDLE);

  // The burst's top halfword only settles in RD_FILL, so the fill cycle reads the bus directly.
  assign cpu_dout = (state == RD_FILL) ? hw_sel(ch1_dout, req_addr[OFF_W-1:0], req_wide) : dout_q;

  sdram_linebuf_store #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_store (
    .clk        (clk),
    .rst_n      (init_n),
    .lk_idx     (cpu_addr[OFF_W +: IDX_W]),
    .lk_tag     (cpu_addr[25 -: TAG_W]),
    .lk_hit     (lk_hit),
    .lk_line    (lk_line),
    .fill_en    (state == RD_FILL),
    .fill_idx   (req_addr[OFF_W +: IDX_W]),
    .fill_tag   (req_addr[25 -: TAG_W]),
    .fill_line  (ch1_dout),
    .fill_valid (!(flush || fill_flushed)),
    .wr_en      ((state == WR_WAIT) && ch1_ready),
    .wr_idx     (req_addr[OFF_W +: IDX_W]),
    .wr_tag     (req_addr[25 -: TAG_W]),
    .wr_off     (req_addr[OFF_W-1:0]),
    .wr_data    (ch1_din),
    .flush      (flush)
  );

  // Request FSM; ch1 address/data/rnw are only reloaded on acceptance so they hold until ready.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state        <= IDLE;
      req_addr     <= '0;
      req_wide     <= 1'b0;
      dout_q       <= '0;
      fill_flushed <= 1'b0;
      cpu_ack      <= 1'b0;
      cpu_busy     <= 1'b0;
      ch1_addr     <= '0;
      ch1_din      <= '0;
      ch1_req      <= 1'b0;
      ch1_rnw      <= 1'b0;
    end else begin
      ch1_req <= 1'b0;
      cpu_ack <= 1'b0;
      if (cpu_ack) cpu_busy <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          cpu_busy     <= 1'b1;
          req_addr     <= cpu_addr;
          req_wide     <= cpu_wide;
          fill_flushed <= 1'b0;
          if (cpu_rnw && lk_hit) begin
            dout_q  <= hw_sel(lk_line, cpu_addr[OFF_W-1:0], cpu_wide);
            cpu_ack <= 1'b1;
          end else if (cpu_rnw) begin
            ch1_addr <= {cpu_addr[25:OFF_W], {OFF_W{1'b0}}};
            ch1_rnw  <= 1'b1;
            ch1_req  <= 1'b1;
            state    <= RD_WAIT;
          end else begin
            ch1_addr <= cpu_addr;
            ch1_din  <= cpu_din;
            ch1_rnw  <= 1'b0;
            ch1_req  <= 1'b1;
            state    <= WR_WAIT;
          end
        end
        RD_WAIT: begin
          if (flush) fill_flushed <= 1'b1;
          if (ch1_ready) begin
            cpu_ack <= 1'b1;
            state   <= RD_FILL;
          end
        end
        RD_FILL: begin
          dout_q <= hw_sel(ch1_dout, req_addr[OFF_W-1:0], req_wide);
          state  <= IDLE;
        end
        WR_WAIT: if (ch1_ready) begin
          cpu_ack <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sdram_rom_linebuf.md
Name: sdram_rom_linebuf

Overview:
- Client-side adapter in front of SDRAM channel 1, which is the 64-bit burst-of-4 read and 16-bit single-write port.
- Serves GBA cartridge-ROM 16/32-bit CPU reads from a small direct-mapped cache of 64-bit lines.
- Issues one channel-1 burst per miss.
- Forwards 16-bit writes (ROM patch and save paths) through to channel 1 and keeps resident lines coherent.

Parameters:
- LINES, 4: number of direct-mapped 64-bit lines; power of two, minimum 2.
- IDX_W, $clog2(LINES): index width, derived.

Ports:
- clk  in  1  system clock, same clock as the SDRAM controller.
- init_n  in  1  reset, asynchronous, active-low.
- cpu_addr  in  26  halfword address [26:1]; for wide reads cpu_addr[1]=0.
- cpu_req  in  1  single-cycle request strobe; accepted only while cpu_busy=0.
- cpu_rnw  in  1  1 = read, 0 = write.
- cpu_wide  in  1  read width; 1 = 32-bit, 0 = 16-bit; ignored on writes.
- cpu_din  in  16  write data.
- cpu_dout  out  32  read data; 16-bit reads are zero-extended.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high from acceptance until the cycle after cpu_ack.
- flush  in  1  invalidate all lines.
- ch1_addr  out  26  to controller.
- ch1_din  out  16  to controller.
- ch1_req  out  1  to controller.
- ch1_rnw  out  1  to controller.
- ch1_dout  in  64  from controller.
- ch1_ready  in  1  from controller.

Behaviour:
- Reset (init_n low) clears all outputs to 0, all valid bits, and the state to IDLE.
- Address split:
  - off = addr[2:1]
  - idx = addr[3+IDX_W-1:3]
  - tag = addr[26:3+IDX_W]
- Line storage: flopped arrays data[LINES][64], tag[LINES], valid[LINES].
- Halfword k of a line is data[16k+15:16k].
- Channel-1 contract:
  - ch1_req is a one-cycle pulse.
  - ch1_addr, ch1_din and ch1_rnw are held stable from the pulse until ch1_ready.
- Read miss data capture: ch1_dout[63:48] settles one cycle after the ch1_ready pulse. Capture the full line on the cycle after ch1_ready, never on ch1_ready itself.
- States: IDLE, RD_WAIT, RD_FILL, WR_WAIT.
- IDLE:
  - On accepted cpu_req, compute hit = valid[idx] && tag match.
  - Read hit: cpu_dout = halfword off (wide: {hw off+1, hw off}); cpu_ack on the next cycle. Hit latency is 1.
  - Read miss: drive ch1_addr = {cpu_addr[26:3],2'b00} (8-byte aligned), ch1_rnw=1, pulse ch1_req, go to RD_WAIT.
  - Write: drive ch1_addr = cpu_addr, ch1_din, ch1_rnw=0, pulse ch1_req, go to WR_WAIT.
- RD_WAIT: on ch1_ready, go to RD_FILL.
- RD_FILL:
  - Write the line, tag and valid=1.
  - Drive cpu_dout from ch1_dout.
  - Pulse cpu_ack; go to IDLE.
  - Miss latency = controller latency + 1.
- WR_WAIT:
  - On ch1_ready, pulse cpu_ack.
  - If the line holding the written address is valid and its tag matches, merge cpu_din into halfword off.
  - Go to IDLE.
- cpu_req while busy is ignored: no queueing and no ack.
- flush:
  - Clears all valid bits in the same cycle.
  - If flush occurs in RD_WAIT or RD_FILL, the fill still returns data to the CPU but leaves valid=0.
  - flush coincident with a hit in IDLE: the hit is served from pre-flush contents, and valid ends up 0.
- A ch1_ready arriving in IDLE is ignored. This covers a stale completion after reset mid-transaction.
- A 16-bit read at off=3 and a wide read at off=2 use only the current line; no line crossing is possible.
- ch1_addr[26] selects the chip and is passed through unmodified.

Decomposition:
- Shared package sdram_pkg holds:
  - halfword and line width constants (16, 64);
  - the channel-1 alignment constant (3 LSBs);
  - the state enum type linebuf_state_t.
- One sub-module: sdram_linebuf_store, holding the tag/valid/data arrays with a lookup port, a fill port, a halfword-merge port and flush.

Test Plan:
- Cold read: cpu_addr=0x0000010 (byte 0x20), 16-bit.
  - Expect one ch1_req at ch1_addr=0x0000010.
  - SDRAM line 0x4444_3333_2222_1111 → cpu_dout=0x00001111.
  - cpu_ack exactly 1 cycle after ch1_ready.
- Hit: wide read of 0x0000012 right after the cold read.
  - Expect no ch1_req.
  - cpu_dout=0x44443333, cpu_ack 1 cycle after cpu_req.
- Conflict eviction (LINES=4): read 0x0000010, then 0x0000030 (same idx, new tag), then 0x0000010.
  - Expect 3 ch1_req pulses, with correct data each time.
- Write coherence: write 0xBEEF to 0x0000011 with the line resident.
  - Expect ch1_req with ch1_rnw=0, ch1_din=0xBEEF.
  - The following 16-bit read of 0x0000011 hits and returns 0x0000BEEF, with no further ch1_req.
- Flush during fill: assert flush in RD_WAIT.
  - The CPU still receives correct data.
  - Re-reading the same address issues a new ch1_req.
- Reset mid-read: pull init_n low in RD_WAIT, release, then deliver a stale ch1_ready.
  - Expect cpu_ack=0 and cpu_busy=0.
  - Expect no line validated.
